// File: rtl/rv_pkg.sv
// Shared constants for the rv_core instruction-fetch front end.
package rv_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [ILEN-1:0] BUBBLE_INSTR = '0;

endpackage

// File: rtl/rv_sync_fifo.sv
// Generic circular-buffer FIFO with occupancy count and synchronous flush.
module rv_sync_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_flush,
  input  logic                       i_wr,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_rd,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr_en = i_wr & ~w_full;
  assign w_rd_en = i_rd & ~o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_wr_en) - CW'(w_rd_en);
    end
  end

endmodule

// File: rtl/rv_fetch_queue.sv
// In-order instruction fetch front end: issues imem requests under a credit limit,
// queues {pc, instr} responses and discards responses made stale by a redirect.
module rv_fetch_queue
  import rv_pkg::*;
#(
  parameter int unsigned     XLEN     = rv_pkg::XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OUT  = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [ILEN-1:0]  imem_rdata_i,
  output logic             instr_valid_o,
  output logic [ILEN-1:0]  instr_o,
  output logic [XLEN-1:0]  pc_o,
  input  logic             instr_ready_i
);

  localparam int unsigned OW = $clog2(MAX_OUT) + 1;
  localparam int unsigned QW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = QW + OW;

  logic [XLEN-1:0]      r_fetch_pc;
  logic [XLEN-1:0]      r_resp_pc;
  logic [OW-1:0]        r_out_cnt;
  logic [OW-1:0]        r_drop_cnt;

  logic [QW-1:0]        w_q_cnt;
  logic                 w_empty;
  logic [XLEN+ILEN-1:0] w_rdata;
  logic [SW-1:0]        w_used;
  logic                 w_req;
  logic                 w_fire;
  logic                 w_drop;
  logic                 w_push;
  logic                 w_pop;
  logic [XLEN-1:0]      w_redir_pc;

  // Live credits: queued entries plus in-flight requests that will still be kept.
  assign w_used     = SW'(w_q_cnt) + SW'(r_out_cnt) - SW'(r_drop_cnt);
  assign w_req      = rstn & ~redirect_i & (w_used < SW'(DEPTH)) & (r_out_cnt < OW'(MAX_OUT));
  assign w_fire     = w_req & imem_gnt_i;
  assign w_drop     = imem_rvalid_i & (r_drop_cnt != '0);
  assign w_push     = imem_rvalid_i & ~w_drop & ~redirect_i;
  assign w_pop      = ~w_empty & instr_ready_i & ~redirect_i;
  assign w_redir_pc = redirect_pc_i & ~XLEN'(3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_out_cnt <= r_out_cnt + OW'(w_fire) - OW'(imem_rvalid_i);
      if (redirect_i) begin
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
        r_drop_cnt <= r_out_cnt - OW'(imem_rvalid_i);
      end else begin
        if (w_fire) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
        if (w_push) r_resp_pc  <= r_resp_pc + XLEN'(PC_STEP);
        if (w_drop) r_drop_cnt <= r_drop_cnt - OW'(1);
      end
    end
  end

  rv_sync_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (redirect_i),
    .i_wr    (w_push),
    .i_wdata ({r_resp_pc, imem_rdata_i}),
    .i_rd    (w_pop),
    .o_rdata (w_rdata),
    .o_count (w_q_cnt),
    .o_empty (w_empty)
  );

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_fetch_pc;
  assign instr_valid_o = ~w_empty;
  assign instr_o       = w_empty ? BUBBLE_INSTR : w_rdata[ILEN-1:0];
  assign pc_o          = w_empty ? '0 : w_rdata[XLEN+ILEN-1:ILEN];

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Randomized bench for rv_fetch_queue with a transaction-level reference model.
module tb_rv_fetch_queue;
  import rv_pkg::*;

  localparam int unsigned     DEPTH    = 4;
  localparam int unsigned     MAX_OUT  = 4;
  localparam logic [63:0]     RESET_PC = '0;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic        instr_ready_i;

  always #5 clk = ~clk;

  rv_fetch_queue #(
    .XLEN     (64),
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i)
  );

  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [63:0] pc; bit stale; } flight_t;
  typedef struct { logic [63:0] a; int t; } pend_t;

  ent_t        m_q[$];
  flight_t     m_fl[$];
  pend_t       pend[$];
  ent_t        obs[$];
  logic [63:0] m_pc;
  int          cyc, last_t;
  int          n_chk, n_fail;
  int          gnt_pct, rdy_pct, lat_min, lat_max, redir_pm;
  bit          redir_on_rv;

  function automatic logic [31:0] mem_f(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ a[63:32] ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fl.delete();
    pend.delete();
    m_pc   = RESET_PC;
    last_t = cyc;
  endtask

  task automatic idle_inputs();
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, instr_valid_o, 0);
    chk({tag, "_req"},   imem_req_o, 0);
    chk({tag, "_addr"},  imem_addr_o, RESET_PC);
    chk({tag, "_pc"},    pc_o, 0);
    chk({tag, "_instr"}, instr_o, 0);
  endtask

  // One clock: drive at negedge, check at negedge+1, advance model to post-edge state.
  task automatic cycle(input bit force_redir, input logic [63:0] fpc);
    bit          rv, rdy, gnt, redir, exp_valid, exp_req;
    logic [31:0] rd;
    logic [63:0] rpc;
    int          live, t;
    flight_t     h;
    @(negedge clk);
    rv = 1'b0;
    rd = '0;
    if (pend.size() > 0 && pend[0].t <= cyc) begin
      rv = 1'b1;
      rd = mem_f(pend[0].a);
    end
    rdy   = ($urandom_range(99) < rdy_pct);
    gnt   = ($urandom_range(99) < gnt_pct);
    redir = force_redir || ($urandom_range(999) < redir_pm) ||
            (redir_on_rv && rv && rdy && m_q.size() > 0);
    rpc   = force_redir ? fpc :
            ($urandom_range(1) == 1) ? {$urandom(), $urandom()} : {52'h0, 12'($urandom())};
    redirect_i    = redir;
    redirect_pc_i = rpc;
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    instr_ready_i = rdy;
    #1;
    live = 0;
    foreach (m_fl[i]) if (!m_fl[i].stale) live++;
    exp_valid = (m_q.size() != 0);
    exp_req   = !redir && (m_q.size() + live < DEPTH) && (m_fl.size() < MAX_OUT);
    chk("valid", instr_valid_o, exp_valid);
    chk("pc",    pc_o,    exp_valid ? m_q[0].pc : 64'h0);
    chk("instr", instr_o, exp_valid ? {32'h0, m_q[0].instr} : 64'h0);
    chk("req",   imem_req_o, exp_req);
    chk("addr",  imem_addr_o, m_pc);
    if (instr_valid_o && rdy && !redir) obs.push_back('{pc_o, instr_o});
    // Memory side reacts to what the DUT actually drives.
    if (imem_req_o && gnt) begin
      t = cyc + int'($urandom_range(lat_max, lat_min));
      if (t <= last_t) t = last_t + 1;
      last_t = t;
      pend.push_back('{imem_addr_o, t});
    end
    if (rv) void'(pend.pop_front());
    if (rv && m_fl.size() > 0) begin
      h = m_fl.pop_front();
      if (!redir && !h.stale) begin
        chk("no_overflow", (m_q.size() < DEPTH), 1);
        m_q.push_back('{h.pc, rd});
      end
    end
    if (redir) begin
      m_q.delete();
      foreach (m_fl[i]) m_fl[i].stale = 1'b1;
      m_pc = rpc & ~64'h3;
    end else begin
      if (exp_valid && rdy) void'(m_q.pop_front());
      if (exp_req && gnt) begin
        m_fl.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 64'd4;
      end
    end
    cyc++;
  endtask

  task automatic set_knobs(input int g, input int r, input int lmin, input int lmax, input int pm);
    gnt_pct = g; rdy_pct = r; lat_min = lmin; lat_max = lmax; redir_pm = pm;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; redir_on_rv = 1'b0;
    idle_inputs();
    rstn = 1'b0;
    #1;
    reset_checks("rst");
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Streaming fill: gnt always, latency 1, ready always.
    set_knobs(100, 100, 1, 1, 0);
    obs.delete();
    repeat (8) cycle(0, '0);
    chk("p1_count", (obs.size() >= 4), 1);
    if (obs.size() >= 4) for (int i = 0; i < 4; i++) chk("p1_pc", obs[i].pc, 64'(i * 4));

    // Back-pressure: queue and credits saturate, request drops.
    set_knobs(100, 0, 1, 1, 0);
    repeat (10) cycle(0, '0);
    chk("p2_req_off", imem_req_o, 0);
    chk("p2_full",    instr_valid_o, 1);
    set_knobs(100, 100, 1, 1, 0);
    obs.delete();
    repeat (12) cycle(0, '0);
    chk("p2_count", (obs.size() >= 8), 1);
    for (int i = 1; i < obs.size(); i++) chk("p2_order", obs[i].pc, obs[0].pc + 64'(i * 4));

    // Redirect with several slow requests in flight.
    set_knobs(100, 100, 3, 3, 0);
    repeat (6) cycle(0, '0);
    cycle(1, 64'h100);
    obs.delete();
    repeat (12) cycle(0, '0);
    chk("p3_count", (obs.size() >= 1), 1);
    if (obs.size() >= 1) begin
      chk("p3_pc",    obs[0].pc, 64'h100);
      chk("p3_instr", obs[0].instr, mem_f(64'h100));
    end

    // Redirects coinciding with a response and a pop.
    set_knobs(80, 100, 1, 3, 0);
    redir_on_rv = 1'b1;
    repeat (60) cycle(0, '0);
    redir_on_rv = 1'b0;

    // Alignment of redirect PC and address wrap.
    set_knobs(0, 100, 1, 2, 0);
    cycle(1, 64'h203);
    cycle(0, '0);
    chk("p5_align", imem_addr_o, 64'h200);
    cycle(1, 64'hFFFF_FFFF_FFFF_FFFC);
    set_knobs(100, 100, 1, 2, 0);
    for (int i = 0; i < 20 && m_pc == 64'hFFFF_FFFF_FFFF_FFFC; i++) cycle(0, '0);
    set_knobs(0, 100, 1, 2, 0);
    cycle(0, '0);
    chk("p5_wrap", imem_addr_o, 64'h0);

    // Asynchronous reset with entries queued.
    set_knobs(100, 0, 1, 1, 0);
    for (int i = 0; i < 20 && m_q.size() < 2; i++) cycle(0, '0);
    chk("p6_pre_valid", instr_valid_o, 1);
    rstn = 1'b0;
    #1;
    reset_checks("p6");
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    set_knobs(100, 100, 1, 1, 0);
    obs.delete();
    repeat (6) cycle(0, '0);
    chk("p6_count", (obs.size() >= 1), 1);
    if (obs.size() >= 1) chk("p6_restart", obs[0].pc, RESET_PC);

    // Fully random traffic with occasional redirects.
    for (int blk = 0; blk < 15; blk++) begin
      set_knobs(int'($urandom_range(100, 20)), int'($urandom_range(100, 10)),
                1, int'($urandom_range(5, 1)), int'($urandom_range(60, 0)));
      redir_on_rv = ($urandom_range(3) == 0);
      repeat (200) cycle(0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
